// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding, sizing defaults and tempo limits for the
// beat sequencer and its pattern store.
package seq_pkg;

    // State codes are visible on the LED output, so the numbering is fixed.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_PLAY   = 2'd2,
        ST_RECORD = 2'd3
    } seq_state_t;

    localparam int SEQ_STEPS  = 16;
    localparam int SEQ_NOTE_W = 4;

    localparam logic [7:0] BPM_MIN     = 8'd30;
    localparam logic [7:0] BPM_MAX     = 8'd240;
    localparam logic [7:0] BPM_DEFAULT = 8'd60;

    // Tick generator needs beat -> max_count -> count, one cycle each.
    localparam int LOAD_CYCLES = 3;

    function automatic logic [7:0] clamp_bpm(input logic [7:0] bpm);
        logic [7:0] result;
        result = bpm;
        if (bpm < BPM_MIN) begin
            result = BPM_MIN;
        end else if (bpm > BPM_MAX) begin
            result = BPM_MAX;
        end
        return result;
    endfunction

endpackage

// File: rtl/seq_pattern_ram.sv
// seq_pattern_ram: STEPS x (valid + note) pattern store.
// One synchronous write port, one asynchronous read port. Reset clears only
// the valid bits; a slot whose valid bit is low is a rest and its note field
// is never looked at.
module seq_pattern_ram
    import seq_pkg::*;
#(
    parameter int STEPS  = SEQ_STEPS,
    parameter int NOTE_W = SEQ_NOTE_W,
    localparam int ADDR_W = $clog2(STEPS)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic              i_wvalid,
    input  logic [NOTE_W-1:0] i_wnote,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic              o_rvalid,
    output logic [NOTE_W-1:0] o_rnote
);

    logic [STEPS-1:0]  r_valid;
    logic [NOTE_W-1:0] r_note [STEPS];

    // Valid bits: cleared by reset, updated on every write.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_waddr] <= i_wvalid;
        end
    end

    // Note field: no reset needed, only meaningful when its valid bit is set.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_note[i_waddr] <= i_wnote;
        end
    end

    assign o_rvalid = r_valid[i_raddr];
    assign o_rnote  = r_note[i_raddr];

endmodule

// File: rtl/beat_sequencer.sv
// beat_sequencer: tempo-driven 16-step note sequencer.
// Configures and gates the beat tick generator, plays the stored pattern to
// the tone generator on each tick, or records live key presses into it.
// Build option: define SEQ_LOOP_EN to wrap the pattern endlessly; otherwise
// the pass ends after the last step and the FSM returns to IDLE.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | stopped; bpm_set accepted, waits for play/rec
// LOAD   | load_bpm held for LOAD_CYCLES, then enters the target state
// PLAY   | each tick plays slot[step] (or silences a rest), step advances
// RECORD | live notes echoed and held pending; each tick writes the slot
module beat_sequencer
    import seq_pkg::*;
#(
    parameter int STEPS       = SEQ_STEPS,
    parameter int NOTE_W      = SEQ_NOTE_W,
    parameter int GATE_CYCLES = 5_000_000,
    localparam int STEP_W     = $clog2(STEPS)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_play_btn,
    input  logic              i_rec_btn,
    input  logic              i_stop_btn,
    input  logic              i_bpm_set,
    input  logic [7:0]        i_bpm_in,
    input  logic              i_tick,
    input  logic              i_note_valid,
    input  logic [NOTE_W-1:0] i_note_in,
    output logic              o_load_bpm,
    output logic [7:0]        o_bpm_out,
    output logic              o_play_en,
    output logic              o_note_on,
    output logic [NOTE_W-1:0] o_note_out,
    output logic [STEP_W-1:0] o_step,
    output logic [1:0]        o_state
);

    localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int LCNT_W = $clog2(LOAD_CYCLES);
    localparam logic [GATE_W-1:0] GATE_RELOAD = GATE_W'(GATE_CYCLES - 1);
    localparam logic [LCNT_W-1:0] LOAD_RELOAD = LCNT_W'(LOAD_CYCLES - 1);

    seq_state_t        r_state;
    seq_state_t        r_target;
    logic [LCNT_W-1:0] r_load_cnt;
    logic [STEP_W-1:0] r_step;
    logic [7:0]        r_bpm;
    logic [GATE_W-1:0] r_gate_cnt;
    logic              r_note_on;
    logic [NOTE_W-1:0] r_note_out;
    logic              r_pend_valid;
    logic [NOTE_W-1:0] r_pend_note;

    seq_state_t        w_state_nx;
    seq_state_t        w_target_nx;
    logic [LCNT_W-1:0] w_load_cnt_nx;
    logic [STEP_W-1:0] w_step_nx;
    logic              w_advance;
    logic              w_bpm_latch;
    logic              w_gate_start;
    logic              w_gate_clear;
    logic              w_note_load;
    logic [NOTE_W-1:0] w_note_nx;
    logic              w_pend_set;
    logic              w_pend_clear;
    logic              w_we;
    logic              w_rd_valid;
    logic [NOTE_W-1:0] w_rd_note;
    logic              w_wr_valid;
    logic [NOTE_W-1:0] w_wr_note;

    // A press coincident with the closing tick still belongs to that window.
    assign w_wr_valid = i_note_valid | r_pend_valid;
    assign w_wr_note  = i_note_valid ? i_note_in : r_pend_note;

    seq_pattern_ram #(
        .STEPS  (STEPS),
        .NOTE_W (NOTE_W)
    ) u_pattern (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_we     (w_we),
        .i_waddr  (r_step),
        .i_wvalid (w_wr_valid),
        .i_wnote  (w_wr_note),
        .i_raddr  (r_step),
        .o_rvalid (w_rd_valid),
        .o_rnote  (w_rd_note)
    );

    // FSM state, LOAD target, LOAD timer and pattern pointer.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state    <= ST_IDLE;
            r_target   <= ST_PLAY;
            r_load_cnt <= '0;
            r_step     <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_target   <= w_target_nx;
            r_load_cnt <= w_load_cnt_nx;
            r_step     <= w_step_nx;
        end
    end

    // Next-state decode and per-state control strobes; stop overrides all.
    always_comb begin
        w_state_nx    = r_state;
        w_target_nx   = r_target;
        w_load_cnt_nx = r_load_cnt;
        w_step_nx     = r_step;
        w_advance     = 1'b0;
        w_bpm_latch   = i_bpm_set && (r_state == ST_IDLE);
        w_gate_start  = 1'b0;
        w_gate_clear  = 1'b0;
        w_note_load   = 1'b0;
        w_note_nx     = r_note_out;
        w_pend_set    = 1'b0;
        w_pend_clear  = 1'b0;
        w_we          = 1'b0;
        o_load_bpm    = (r_state == ST_LOAD);
        o_play_en     = (r_state == ST_PLAY) || (r_state == ST_RECORD);

        if (i_stop_btn) begin
            w_state_nx   = ST_IDLE;
            w_step_nx    = '0;
            w_gate_clear = 1'b1;
            w_pend_clear = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_rec_btn) begin
                        w_state_nx    = ST_LOAD;
                        w_target_nx   = ST_RECORD;
                        w_load_cnt_nx = LOAD_RELOAD;
                    end else if (i_play_btn) begin
                        w_state_nx    = ST_LOAD;
                        w_target_nx   = ST_PLAY;
                        w_load_cnt_nx = LOAD_RELOAD;
                    end
                end
                ST_LOAD: begin
                    w_pend_clear = 1'b1;
                    if (r_load_cnt == '0) begin
                        w_state_nx = r_target;
                        w_step_nx  = '0;
                    end else begin
                        w_load_cnt_nx = r_load_cnt - LCNT_W'(1);
                    end
                end
                ST_PLAY: begin
                    if (i_tick) begin
                        if (w_rd_valid) begin
                            w_note_load  = 1'b1;
                            w_note_nx    = w_rd_note;
                            w_gate_start = 1'b1;
                        end else begin
                            w_gate_clear = 1'b1;
                        end
                        w_advance = 1'b1;
                    end
                end
                ST_RECORD: begin
                    if (i_note_valid) begin
                        w_pend_set   = 1'b1;
                        w_note_load  = 1'b1;
                        w_note_nx    = i_note_in;
                        w_gate_start = 1'b1;
                    end
                    if (i_tick) begin
                        w_we         = 1'b1;
                        w_pend_clear = 1'b1;
                        w_advance    = 1'b1;
                    end
                end
                default: begin
                    w_state_nx = ST_IDLE;
                end
            endcase

            if (w_advance) begin
`ifdef SEQ_LOOP_EN
                w_step_nx = r_step + STEP_W'(1);
`else
                if (r_step == STEP_W'(STEPS - 1)) begin
                    w_state_nx = ST_IDLE;
                    w_step_nx  = '0;
                end else begin
                    w_step_nx = r_step + STEP_W'(1);
                end
`endif
            end
        end
    end

    // Tempo register, clamped to the supported range as it is latched.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_bpm <= BPM_DEFAULT;
        end else if (w_bpm_latch) begin
            r_bpm <= clamp_bpm(i_bpm_in);
        end
    end

    // Note gate: down-counter; note_on covers the load cycle plus the
    // countdown, so a retrigger keeps it high with no gap.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_gate_cnt <= '0;
            r_note_on  <= 1'b0;
            r_note_out <= '0;
        end else begin
            if (w_note_load) begin
                r_note_out <= w_note_nx;
            end
            if (w_gate_start) begin
                r_gate_cnt <= GATE_RELOAD;
                r_note_on  <= 1'b1;
            end else if (w_gate_clear) begin
                r_gate_cnt <= '0;
                r_note_on  <= 1'b0;
            end else begin
                r_note_on <= (r_gate_cnt != '0);
                if (r_gate_cnt != '0) begin
                    r_gate_cnt <= r_gate_cnt - GATE_W'(1);
                end
            end
        end
    end

    // Pending live note for the current record window; clearing wins so a
    // press on the closing tick does not leak into the next window.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_pend_valid <= 1'b0;
            r_pend_note  <= '0;
        end else if (w_pend_clear) begin
            r_pend_valid <= 1'b0;
        end else if (w_pend_set) begin
            r_pend_valid <= 1'b1;
            r_pend_note  <= i_note_in;
        end
    end

    assign o_bpm_out  = r_bpm;
    assign o_note_on  = r_note_on;
    assign o_note_out = r_note_out;
    assign o_step     = r_step;
    assign o_state    = r_state;

endmodule

// File: tb/tb_beat_sequencer.sv
// Testbench for beat_sequencer: directed scenarios checked against fixed
// expected values, then randomized traffic checked every cycle against a
// behavioural model of the sequencer rules.
module tb_beat_sequencer;

    localparam int G = 4;
    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_PLAY = 2;
    localparam int M_REC  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       play_btn = 1'b0, rec_btn = 1'b0, stop_btn = 1'b0, bpm_set = 1'b0;
    logic [7:0] bpm_in = '0;
    logic       tick = 1'b0, note_valid = 1'b0;
    logic [3:0] note_in = '0;
    logic       load_bpm, play_en, note_on;
    logic [7:0] bpm_out;
    logic [3:0] note_out, step;
    logic [1:0] state;

    always #10 clk = ~clk;

    beat_sequencer #(.STEPS(16), .NOTE_W(4), .GATE_CYCLES(G)) dut (
        .i_clk(clk), .i_reset(rst_n),
        .i_play_btn(play_btn), .i_rec_btn(rec_btn), .i_stop_btn(stop_btn),
        .i_bpm_set(bpm_set), .i_bpm_in(bpm_in), .i_tick(tick),
        .i_note_valid(note_valid), .i_note_in(note_in),
        .o_load_bpm(load_bpm), .o_bpm_out(bpm_out), .o_play_en(play_en),
        .o_note_on(note_on), .o_note_out(note_out), .o_step(step), .o_state(state)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state.
    int m_mode, m_target, m_load_left, m_step, m_bpm, m_gate_left, m_note_out;
    int m_pend_v, m_pend_n;
    int m_pv[16];
    int m_pn[16];

    function automatic int clamp(input int b);
        return (b < 30) ? 30 : ((b > 240) ? 240 : b);
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_target = M_PLAY; m_load_left = 0; m_step = 0;
        m_bpm = 60; m_gate_left = 0; m_note_out = 0; m_pend_v = 0; m_pend_n = 0;
        for (int i = 0; i < 16; i++) begin
            m_pv[i] = 0;
            m_pn[i] = 0;
        end
    endtask

    task automatic model_advance();
`ifdef SEQ_LOOP_EN
        m_step = (m_step + 1) % 16;
`else
        if (m_step == 15) begin
            m_mode = M_IDLE;
            m_step = 0;
        end else begin
            m_step = m_step + 1;
        end
`endif
    endtask

    // One clock of sequencer behaviour; gate length counts whole cycles.
    task automatic model_step(input int st, input int rc, input int pl, input int bs,
                              input int bpm, input int tk, input int nv, input int nt);
        if (m_gate_left > 0) m_gate_left = m_gate_left - 1;
        if (m_mode == M_IDLE && bs != 0) m_bpm = clamp(bpm);
        if (st != 0) begin
            m_mode = M_IDLE; m_step = 0; m_gate_left = 0; m_pend_v = 0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (rc != 0) begin
                        m_mode = M_LOAD; m_target = M_REC; m_load_left = 3;
                    end else if (pl != 0) begin
                        m_mode = M_LOAD; m_target = M_PLAY; m_load_left = 3;
                    end
                end
                M_LOAD: begin
                    m_pend_v = 0;
                    m_load_left = m_load_left - 1;
                    if (m_load_left == 0) begin
                        m_mode = m_target;
                        m_step = 0;
                    end
                end
                M_PLAY: begin
                    if (tk != 0) begin
                        if (m_pv[m_step] != 0) begin
                            m_note_out = m_pn[m_step];
                            m_gate_left = G;
                        end else begin
                            m_gate_left = 0;
                        end
                        model_advance();
                    end
                end
                default: begin
                    if (nv != 0) begin
                        m_pend_v = 1; m_pend_n = nt;
                        m_note_out = nt; m_gate_left = G;
                    end
                    if (tk != 0) begin
                        m_pv[m_step] = m_pend_v;
                        m_pn[m_step] = m_pend_n;
                        m_pend_v = 0;
                        model_advance();
                    end
                end
            endcase
        end
    endtask

    task automatic cyc(input logic st, input logic rc, input logic pl, input logic bs,
                       input logic [7:0] bpm, input logic tk, input logic nv, input logic [3:0] nt);
        stop_btn = st; rec_btn = rc; play_btn = pl; bpm_set = bs; bpm_in = bpm;
        tick = tk; note_valid = nv; note_in = nt;
        model_step(int'(st), int'(rc), int'(pl), int'(bs), int'(bpm), int'(tk), int'(nv), int'(nt));
        @(posedge clk);
        #1;
    endtask

    task automatic t_idle();              cyc(0, 0, 0, 0, 8'd0, 0, 0, 4'd0); endtask
    task automatic t_tick();              cyc(0, 0, 0, 0, 8'd0, 1, 0, 4'd0); endtask
    task automatic t_note(input logic [3:0] n);      cyc(0, 0, 0, 0, 8'd0, 0, 1, n); endtask
    task automatic t_tick_note(input logic [3:0] n); cyc(0, 0, 0, 0, 8'd0, 1, 1, n); endtask
    task automatic t_stop();              cyc(1, 0, 0, 0, 8'd0, 0, 0, 4'd0); endtask
    task automatic t_bpm(input logic [7:0] b);       cyc(0, 0, 0, 1, b, 0, 0, 4'd0); endtask

    task automatic press_play();
        cyc(0, 0, 1, 0, 8'd0, 0, 0, 4'd0);
        repeat (3) t_idle();
    endtask

    task automatic press_rec();
        cyc(0, 1, 0, 0, 8'd0, 0, 0, 4'd0);
        repeat (3) t_idle();
    endtask

    task automatic test_reset();
        logic [20:0] got;
        rst_n = 1'b0;
        stop_btn = 0; rec_btn = 0; play_btn = 0; bpm_set = 0; tick = 0; note_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        got = {state, step, note_on, note_out, load_bpm, play_en, bpm_out};
        n_checks++;
        if (got !== {2'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 8'd60}) begin
            n_errors++;
            $display("FAIL reset_values: got %h expected %h", got, {2'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 8'd60});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_bpm_load();
        // 8-bit input cannot carry 300; 250 exercises the same upper clamp.
        t_bpm(8'd250);
        n_checks++;
        if (bpm_out !== 8'd240) begin n_errors++; $display("FAIL bpm_clamp_hi: got %0d expected 240", bpm_out); end
        t_bpm(8'd10);
        n_checks++;
        if (bpm_out !== 8'd30) begin n_errors++; $display("FAIL bpm_clamp_lo: got %0d expected 30", bpm_out); end
        t_bpm(8'd250);
        cyc(0, 0, 1, 0, 8'd0, 0, 0, 4'd0);
        n_checks++;
        if ({state, load_bpm, play_en} !== {2'd1, 1'b1, 1'b0}) begin
            n_errors++; $display("FAIL load_c1: state %0d load %b en %b expected 1 1 0", state, load_bpm, play_en);
        end
        t_idle();
        n_checks++;
        if (load_bpm !== 1'b1) begin n_errors++; $display("FAIL load_c2: got %b expected 1", load_bpm); end
        t_idle();
        n_checks++;
        if (load_bpm !== 1'b1) begin n_errors++; $display("FAIL load_c3: got %b expected 1", load_bpm); end
        t_idle();
        n_checks++;
        if ({state, load_bpm, play_en, bpm_out} !== {2'd2, 1'b0, 1'b1, 8'd240}) begin
            n_errors++; $display("FAIL load_done: state %0d load %b en %b bpm %0d expected 2 0 1 240", state, load_bpm, play_en, bpm_out);
        end
        t_bpm(8'd100);
        n_checks++;
        if (bpm_out !== 8'd240) begin n_errors++; $display("FAIL bpm_ignored_in_play: got %0d expected 240", bpm_out); end
        t_stop();
        n_checks++;
        if (state !== 2'd0) begin n_errors++; $display("FAIL stop_to_idle: got %0d expected 0", state); end
    endtask

    task automatic test_record_play();
        press_rec();
        n_checks++;
        if ({state, play_en, step} !== {2'd3, 1'b1, 4'd0}) begin
            n_errors++; $display("FAIL rec_entry: state %0d en %b step %0d expected 3 1 0", state, play_en, step);
        end
        t_note(4'd5);
        n_checks++;
        if ({note_on, note_out} !== {1'b1, 4'd5}) begin
            n_errors++; $display("FAIL rec_echo: on %b note %0d expected 1 5", note_on, note_out);
        end
        t_tick();
        t_note(4'd2); t_idle(); t_note(4'd7); t_tick();
        t_tick();
        t_tick_note(4'd9);
        n_checks++;
        if ({state, step} !== {2'd3, 4'd4}) begin
            n_errors++; $display("FAIL rec_step: state %0d step %0d expected 3 4", state, step);
        end
        t_stop();
        press_play();
        t_tick();
        n_checks++;
        if ({note_on, note_out, step} !== {1'b1, 4'd5, 4'd1}) begin
            n_errors++; $display("FAIL play_slot0: on %b note %0d step %0d expected 1 5 1", note_on, note_out, step);
        end
        t_idle(); t_idle();
        t_tick();
        n_checks++;
        if ({note_on, note_out} !== {1'b1, 4'd7}) begin
            n_errors++; $display("FAIL play_slot1_overwrite: on %b note %0d expected 1 7", note_on, note_out);
        end
        t_idle();
        t_tick();
        n_checks++;
        if (note_on !== 1'b0) begin n_errors++; $display("FAIL play_slot2_rest: on %b expected 0", note_on); end
        t_tick();
        n_checks++;
        if ({note_on, note_out} !== {1'b1, 4'd9}) begin
            n_errors++; $display("FAIL play_slot3_coincident: on %b note %0d expected 1 9", note_on, note_out);
        end
        t_tick();
        n_checks++;
        if (note_on !== 1'b0) begin n_errors++; $display("FAIL play_slot4_untouched: on %b expected 0", note_on); end
        t_stop();
    endtask

    task automatic test_gate_retrigger();
        press_play();
        t_tick();
        n_checks++;
        if ({note_on, note_out} !== {1'b1, 4'd5}) begin
            n_errors++; $display("FAIL retrig_t1: on %b note %0d expected 1 5", note_on, note_out);
        end
        t_idle();
        n_checks++;
        if (note_on !== 1'b1) begin n_errors++; $display("FAIL retrig_gap1: on %b expected 1", note_on); end
        t_tick();
        n_checks++;
        if ({note_on, note_out} !== {1'b1, 4'd7}) begin
            n_errors++; $display("FAIL retrig_t2: on %b note %0d expected 1 7", note_on, note_out);
        end
        t_idle(); t_idle(); t_idle();
        n_checks++;
        if (note_on !== 1'b1) begin n_errors++; $display("FAIL gate_last_cycle: on %b expected 1", note_on); end
        t_idle();
        n_checks++;
        if (note_on !== 1'b0) begin n_errors++; $display("FAIL gate_expired: on %b expected 0", note_on); end
        t_stop();
    endtask

    task automatic test_stop_tick();
        press_play();
        repeat (6) begin t_tick(); t_idle(); end
        n_checks++;
        if (step !== 4'd6) begin n_errors++; $display("FAIL pre_stop_step: got %0d expected 6", step); end
        t_tick();
        t_idle();
        cyc(1, 0, 0, 0, 8'd0, 1, 0, 4'd0);
        n_checks++;
        if ({state, step, note_on} !== {2'd0, 4'd0, 1'b0}) begin
            n_errors++; $display("FAIL stop_wins: state %0d step %0d on %b expected 0 0 0", state, step, note_on);
        end
        press_play();
        t_tick();
        n_checks++;
        if ({note_on, note_out, step} !== {1'b1, 4'd5, 4'd1}) begin
            n_errors++; $display("FAIL replay_slot0: on %b note %0d step %0d expected 1 5 1", note_on, note_out, step);
        end
        t_tick();
        n_checks++;
        if (note_out !== 4'd7) begin n_errors++; $display("FAIL replay_slot1: got %0d expected 7", note_out); end
        t_stop();
    endtask

    task automatic test_last_step();
        press_play();
        repeat (16) begin t_tick(); t_idle(); end
`ifdef SEQ_LOOP_EN
        n_checks++;
        if ({state, step} !== {2'd2, 4'd0}) begin
            n_errors++; $display("FAIL wrap: state %0d step %0d expected 2 0", state, step);
        end
        t_tick();
        n_checks++;
        if ({note_on, note_out, step} !== {1'b1, 4'd5, 4'd1}) begin
            n_errors++; $display("FAIL wrap_slot0: on %b note %0d step %0d expected 1 5 1", note_on, note_out, step);
        end
`else
        n_checks++;
        if ({state, step, play_en} !== {2'd0, 4'd0, 1'b0}) begin
            n_errors++; $display("FAIL end_of_pass: state %0d step %0d en %b expected 0 0 0", state, step, play_en);
        end
`endif
        t_stop();
    endtask

    task automatic test_reset_mid_load();
        cyc(0, 0, 1, 0, 8'd0, 0, 0, 4'd0);
        t_idle();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if ({state, load_bpm} !== {2'd0, 1'b0}) begin
            n_errors++; $display("FAIL reset_mid_load: state %0d load %b expected 0 0", state, load_bpm);
        end
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [20:0] got, exp;
        logic st, rc, pl, bs, tk, nv;
        logic [7:0] b;
        logic [3:0] n;
        for (int i = 0; i < 4000; i++) begin
            st = ($urandom_range(0, 119) == 0);
            rc = ($urandom_range(0, 59) == 0);
            pl = ($urandom_range(0, 49) == 0);
            bs = ($urandom_range(0, 19) == 0);
            tk = ($urandom_range(0, 3) == 0);
            nv = ($urandom_range(0, 4) == 0);
            b  = 8'($urandom_range(0, 255));
            n  = 4'($urandom_range(0, 15));
            cyc(st, rc, pl, bs, b, tk, nv, n);
            exp = {2'(m_mode), 4'(m_step), (m_gate_left > 0), 4'(m_note_out),
                   (m_mode == M_LOAD), (m_mode == M_PLAY || m_mode == M_REC), 8'(m_bpm)};
            got = {state, step, note_on, note_out, load_bpm, play_en, bpm_out};
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL random_cycle_%0d: got %h expected %h", i, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bpm_load();
        test_record_play();
        test_gate_retrigger();
        test_stop_tick();
        test_last_step();
        test_reset_mid_load();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
